// File: rtl/ym3438_pkg.sv
// Shared definitions for the YM3438 register write scheduler.
//   SLOT_COUNT      : operator slots per sequencer cycle
//   ADDR_*          : register address ranges for global / operator / channel registers
//   OP_GROUP_MAP    : operator group for each value of addr[3:2]
//   KIND_*          : encoding of the reg_kind output
//   state_e         : scheduler FSM states
//   op_slot()       : operator slot from addr[3:2] and channel index
package ym3438_pkg;

  localparam int unsigned SLOT_COUNT = 24;

  localparam logic [7:0] ADDR_GLOB_LO = 8'h20;
  localparam logic [7:0] ADDR_GLOB_HI = 8'h2F;
  localparam logic [7:0] ADDR_OP_LO   = 8'h30;
  localparam logic [7:0] ADDR_OP_HI   = 8'h9F;
  localparam logic [7:0] ADDR_CH_LO   = 8'hA0;
  localparam logic [7:0] ADDR_CH_HI   = 8'hB7;

  // addr[3:2] = 0,1,2,3 selects operator group 1,2,3,0
  localparam logic [1:0] OP_GROUP_MAP [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

  localparam logic KIND_OP = 1'b0;
  localparam logic KIND_CH = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StWaitSlot,
    StHold
  } state_e;

  function automatic logic [4:0] op_slot(input logic [1:0] sel, input logic [2:0] ch);
    logic [1:0] grp;
    grp = OP_GROUP_MAP[sel];
    return ({3'b000, grp} * 5'd6) + {2'b00, ch};
  endfunction

endpackage

// File: rtl/ym3438_wr_decode.sv
// Combinational register address decoder.
//   i_addr   : latched register address
//   i_port   : latched register port (0/1)
//   o_kind   : 0 = operator register, 1 = channel register
//   o_valid  : address targets an operator or channel slot register
//   o_global : address targets a global register (port 0, 0x20..0x2F)
//   o_slot   : target slot 0..23; 0 when o_valid is low
module ym3438_wr_decode
  import ym3438_pkg::*;
(
  input  logic [7:0] i_addr,
  input  logic       i_port,
  output logic       o_kind,
  output logic       o_valid,
  output logic       o_global,
  output logic [4:0] o_slot
);

  logic [2:0] w_ch;
  logic       w_ch_ok;
  logic       w_in_glob;
  logic       w_in_op;
  logic       w_in_ch;

  always_comb begin
    w_ch      = {1'b0, i_addr[1:0]} + (i_port ? 3'd3 : 3'd0);
    // ch field value 3 does not address any channel
    w_ch_ok   = (i_addr[1:0] != 2'd3);
    w_in_glob = (i_addr >= ADDR_GLOB_LO) && (i_addr <= ADDR_GLOB_HI);
    w_in_op   = (i_addr >= ADDR_OP_LO) && (i_addr <= ADDR_OP_HI);
    w_in_ch   = (i_addr >= ADDR_CH_LO) && (i_addr <= ADDR_CH_HI);

    o_global = w_in_glob & ~i_port;
    o_valid  = 1'b0;
    o_kind   = KIND_OP;
    o_slot   = 5'd0;
    if (w_in_op && w_ch_ok) begin
      o_valid = 1'b1;
      o_kind  = KIND_OP;
      o_slot  = op_slot(i_addr[3:2], w_ch);
    end else if (w_in_ch && w_ch_ok) begin
      o_valid = 1'b1;
      o_kind  = KIND_CH;
      o_slot  = {2'b00, w_ch};
    end
  end

endmodule

// File: rtl/ym3438_reg_write_sched.sv
// YM3438 bus write scheduler: latches address writes, accepts data writes while idle,
// issues a global write strobe or waits for the target operator slot before issuing a
// slot register strobe, and keeps busy high for BUSY_TICKS slot ticks per accepted write.
//   i_mclk, i_reset      : clock, synchronous active-high reset
//   i_slot_tick, i_slot0 : operator sequencer step pulse / slot 0 indicator
//   i_wr, i_a0, i_a1     : bus write strobe, address/data select, port select
//   i_din                : bus write data
//   o_busy               : write in progress
//   o_drop_flag          : sticky, a data write arrived while busy and was discarded
//   o_glob_we, o_reg_we  : global / slot register write strobes
//   o_reg_kind           : 0 = operator register, 1 = channel register
//   o_reg_addr/data/slot : address, data and target slot of the current or last write
module ym3438_reg_write_sched
  import ym3438_pkg::*;
#(
  parameter int unsigned BUSY_TICKS = 32
) (
  input  logic       i_mclk,
  input  logic       i_reset,
  input  logic       i_slot_tick,
  input  logic       i_slot0,
  input  logic       i_wr,
  input  logic       i_a0,
  input  logic       i_a1,
  input  logic [7:0] i_din,
  output logic       o_busy,
  output logic       o_drop_flag,
  output logic       o_glob_we,
  output logic       o_reg_we,
  output logic       o_reg_kind,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_data,
  output logic [4:0] o_reg_slot
);

  localparam logic [5:0] BUSY_LIMIT = 6'(BUSY_TICKS);
  localparam logic [4:0] SLOT_LAST  = 5'(SLOT_COUNT - 1);

  state_e     r_state;
  state_e     w_state_next;
  logic [4:0] r_cnt;
  logic [5:0] r_busy_cnt;
  logic [5:0] w_busy_cnt_next;
  logic [7:0] r_addr_lat;
  logic       r_port_lat;
  logic       r_glob_we;
  logic       r_drop_flag;
  logic       r_reg_kind;
  logic [7:0] r_reg_addr;
  logic [7:0] r_reg_data;
  logic [4:0] r_reg_slot;

  logic       w_addr_wr;
  logic       w_data_wr;
  logic       w_accept;
  logic       w_reg_we;
  logic [4:0] w_cur_slot;
  logic       w_dec_kind;
  logic       w_dec_valid;
  logic       w_dec_global;
  logic [4:0] w_dec_slot;

  assign w_addr_wr  = i_wr & ~i_a0;
  assign w_data_wr  = i_wr & i_a0;
  assign w_accept   = w_data_wr & (r_state == StIdle);
  assign w_cur_slot = i_slot0 ? 5'd0 : r_cnt;

  ym3438_wr_decode u_decode (
    .i_addr   (r_addr_lat),
    .i_port   (r_port_lat),
    .o_kind   (w_dec_kind),
    .o_valid  (w_dec_valid),
    .o_global (w_dec_global),
    .o_slot   (w_dec_slot)
  );

  always_comb begin
    w_state_next    = r_state;
    w_busy_cnt_next = r_busy_cnt;
    w_reg_we        = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_busy_cnt_next = 6'd0;
          // global and invalid writes have no slot to wait for
          if (w_dec_valid && !w_dec_global) begin
            w_state_next = StWaitSlot;
          end else begin
            w_state_next = StHold;
          end
        end
      end
      StWaitSlot: begin
        if (i_slot_tick) begin
          w_busy_cnt_next = r_busy_cnt + 6'd1;
        end
        if (i_slot_tick && (w_cur_slot == r_reg_slot)) begin
          w_reg_we     = ~i_reset;
          w_state_next = StHold;
        end
      end
      StHold: begin
        if (i_slot_tick) begin
          w_busy_cnt_next = r_busy_cnt + 6'd1;
        end
        if (w_busy_cnt_next >= BUSY_LIMIT) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_mclk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_cnt       <= 5'd0;
      r_busy_cnt  <= 6'd0;
      r_addr_lat  <= 8'd0;
      r_port_lat  <= 1'b0;
      r_glob_we   <= 1'b0;
      r_drop_flag <= 1'b0;
      r_reg_kind  <= 1'b0;
      r_reg_addr  <= 8'd0;
      r_reg_data  <= 8'd0;
      r_reg_slot  <= 5'd0;
    end else begin
      r_state    <= w_state_next;
      r_busy_cnt <= w_busy_cnt_next;
      if (i_slot_tick) begin
        r_cnt <= i_slot0 ? 5'd1 : ((r_cnt == SLOT_LAST) ? 5'd0 : r_cnt + 5'd1);
      end
      if (w_addr_wr) begin
        r_addr_lat <= i_din;
        r_port_lat <= i_a1;
      end
      r_glob_we <= w_accept & w_dec_global;
      // global and invalid writes record slot 0 / operator kind
      if (w_accept) begin
        r_reg_addr <= r_addr_lat;
        r_reg_data <= i_din;
        r_reg_slot <= w_dec_slot;
        r_reg_kind <= w_dec_kind;
      end
      if (w_data_wr && (r_state != StIdle)) begin
        r_drop_flag <= 1'b1;
      end
    end
  end

  assign o_busy      = (r_state != StIdle);
  assign o_drop_flag = r_drop_flag;
  assign o_glob_we   = r_glob_we;
  assign o_reg_we    = w_reg_we;
  assign o_reg_kind  = r_reg_kind;
  assign o_reg_addr  = r_reg_addr;
  assign o_reg_data  = r_reg_data;
  assign o_reg_slot  = r_reg_slot;

endmodule
